// File: rtl/req11_resolver_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : req11_resolver_pkg
//  Purpose  : Shared constants, FSM state type and index helper for the
//             11-way request resolver.
//  Contents : NREQ (request count), IDXW (grant index width),
//             state_t {IDLE, GRANT}, next_idx() modulo-11 increment.
//  Revision : 1.0 - initial release
// ============================================================================
package req11_resolver_pkg;

    localparam int NREQ = 11;
    localparam int IDXW = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Increment an index modulo NREQ. Any value at or above the top index
    // wraps to 0, so the round-robin scan always stays inside 0..10.
    function automatic logic [IDXW-1:0] next_idx(input logic [IDXW-1:0] i);
        logic [IDXW-1:0] r;
        if (i >= IDXW'(NREQ - 1)) begin
            r = '0;
        end else begin
            r = i + 1'b1;
        end
        return r;
    endfunction

endpackage : req11_resolver_pkg
`default_nettype wire

// File: rtl/req11_resolver_rr_pick11.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick11
//  Purpose  : Combinational winner selection among 11 pending bits.
//  Ports    : p_i      [10:0] pending vector
//             lp_i     [3:0]  last granted index (round-robin pointer)
//             rr_i            1 = round-robin from lp_i+1, 0 = lowest bit wins
//             found_o         at least one pending bit
//             onehot_o [10:0] one-hot winner (zero when nothing pending)
//             idx_o    [3:0]  binary winner index (zero when nothing pending)
//  Revision : 1.0 - initial release
// ============================================================================
module rr_pick11
    import req11_resolver_pkg::*;
(
    input  logic [NREQ-1:0] p_i,
    input  logic [IDXW-1:0] lp_i,
    input  logic            rr_i,
    output logic            found_o,
    output logic [NREQ-1:0] onehot_o,
    output logic [IDXW-1:0] idx_o
);

    logic [IDXW-1:0] cur_d;

    always_comb begin
        found_o  = 1'b0;
        idx_o    = '0;
        onehot_o = '0;
        cur_d    = next_idx(lp_i);
        if (rr_i) begin
            // Walk the ring starting just after the last grant; the first
            // hit is kept, later hits are ignored.
            for (int k = 0; k < NREQ; k++) begin
                if (!found_o && p_i[cur_d]) begin
                    found_o = 1'b1;
                    idx_o   = cur_d;
                end
                cur_d = next_idx(cur_d);
            end
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                if (!found_o && p_i[k]) begin
                    found_o = 1'b1;
                    idx_o   = IDXW'(k);
                end
            end
        end
        if (found_o) begin
            onehot_o[idx_o] = 1'b1;
        end
    end

endmodule : rr_pick11
`default_nettype wire

// File: rtl/req11_resolver.sv
`default_nettype none
// ============================================================================
//  Module   : req11_resolver
//  Purpose  : Captures 11 request lines into a sticky pending register,
//             reports "any pending" (Z0) and serves pending sources one at a
//             time as a held one-hot grant plus binary index until ACK.
//  Params   : EDGE  0 = level capture, 1 = rising-edge capture
//             RR    1 = round-robin after last grant, 0 = fixed (A[0] highest)
//  Ports    : CK    clock (rising edge)
//             CDN   asynchronous active-low reset
//             A     [10:0] request lines
//             ACK   service-complete strobe, honoured only while granting
//             Z0    registered OR of the next pending state
//             VLD   grant valid
//             GNT   [10:0] one-hot grant (zero when VLD=0)
//             IDX   [3:0]  grant index 0..10 (zero when VLD=0)
//  Revision : 1.0 - initial release
// ============================================================================
module req11_resolver
    import req11_resolver_pkg::*;
#(
    parameter bit EDGE = 1'b0,
    parameter bit RR   = 1'b1
)
(
    input  logic            CK,
    input  logic            CDN,
    input  logic [NREQ-1:0] A,
    input  logic            ACK,
    output logic            Z0,
    output logic            VLD,
    output logic [NREQ-1:0] GNT,
    output logic [IDXW-1:0] IDX
);

    state_t          state_q;
    logic [NREQ-1:0] pend_q;
    logic [NREQ-1:0] pend_d;
    logic [NREQ-1:0] aq_q;
    logic [IDXW-1:0] lp_q;
    logic            z0_q;
    logic            vld_q;
    logic [NREQ-1:0] gnt_q;
    logic [IDXW-1:0] idx_q;

    logic [NREQ-1:0] req_set;
    logic [NREQ-1:0] req_clr;
    logic            pick_found;
    logic [NREQ-1:0] pick_onehot;
    logic [IDXW-1:0] pick_idx;

    assign req_set = EDGE ? (A & ~aq_q) : A;
    // The served bit is retired only in the cycle the consumer acknowledges.
    assign req_clr = ((state_q == GRANT) && ACK) ? gnt_q : '0;
    // Set is applied after clear so a re-request in the ACK cycle survives.
    assign pend_d  = (pend_q & ~req_clr) | req_set;

    rr_pick11 u_pick (
        .p_i      (pend_q),
        .lp_i     (lp_q),
        .rr_i     (RR),
        .found_o  (pick_found),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx)
    );

    always_ff @(posedge CK or negedge CDN) begin
        if (!CDN) begin
            state_q <= IDLE;
            pend_q  <= '0;
            aq_q    <= '0;
            lp_q    <= IDXW'(NREQ - 1);
            z0_q    <= 1'b0;
            vld_q   <= 1'b0;
            gnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            aq_q   <= A;
            pend_q <= pend_d;
            z0_q   <= |pend_d;
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        gnt_q   <= pick_onehot;
                        idx_q   <= pick_idx;
                        vld_q   <= 1'b1;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    // Grant is frozen until ACK; the return to IDLE forces
                    // one bubble cycle before the next grant.
                    if (ACK) begin
                        lp_q    <= idx_q;
                        gnt_q   <= '0;
                        idx_q   <= '0;
                        vld_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Z0  = z0_q;
    assign VLD = vld_q;
    assign GNT = gnt_q;
    assign IDX = idx_q;

endmodule : req11_resolver
`default_nettype wire

// File: tb/tb_req11_resolver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_req11_resolver
//  Purpose  : Self-checking bench for req11_resolver. Three instances cover
//             level/round-robin, level/fixed-priority and edge/round-robin.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_req11_resolver;

    logic        ck  = 1'b0;
    logic        cdn = 1'b0;
    logic [10:0] a_i   [3];
    logic        ack_i [3];
    logic        z0_o  [3];
    logic        vld_o [3];
    logic [10:0] gnt_o [3];
    logic [3:0]  idx_o [3];

    int vectors     = 0;
    int miscompares = 0;

    always #5 ck = ~ck;

    req11_resolver #(.EDGE(1'b0), .RR(1'b1)) u_rr (
        .CK(ck), .CDN(cdn), .A(a_i[0]), .ACK(ack_i[0]),
        .Z0(z0_o[0]), .VLD(vld_o[0]), .GNT(gnt_o[0]), .IDX(idx_o[0]));

    req11_resolver #(.EDGE(1'b0), .RR(1'b0)) u_fp (
        .CK(ck), .CDN(cdn), .A(a_i[1]), .ACK(ack_i[1]),
        .Z0(z0_o[1]), .VLD(vld_o[1]), .GNT(gnt_o[1]), .IDX(idx_o[1]));

    req11_resolver #(.EDGE(1'b1), .RR(1'b1)) u_edge (
        .CK(ck), .CDN(cdn), .A(a_i[2]), .ACK(ack_i[2]),
        .Z0(z0_o[2]), .VLD(vld_o[2]), .GNT(gnt_o[2]), .IDX(idx_o[2]));

    // ---------------- reference model (one per instance) ----------------
    logic [10:0] m_pend  [3];
    logic [10:0] m_aprev [3];
    int          m_last  [3];
    int          m_gidx  [3];
    bit          m_busy  [3];
    bit          m_z0    [3];

    function automatic bit rr_of(int d);   return d != 1; endfunction
    function automatic bit edge_of(int d); return d == 2; endfunction

    function automatic int pick(int d);
        if (rr_of(d)) begin
            for (int k = 1; k <= 11; k++) begin
                int j = (m_last[d] + k) % 11;
                if (m_pend[d][j]) return j;
            end
        end else begin
            for (int k = 0; k < 11; k++)
                if (m_pend[d][k]) return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_pend[d] = '0; m_aprev[d] = '0; m_last[d] = 10;
            m_gidx[d] = 0;  m_busy[d]  = 1'b0; m_z0[d] = 1'b0;
        end
    endtask

    task automatic model_clock(int d);
        logic [10:0] nxt;
        logic [10:0] setv;
        int w;
        setv = edge_of(d) ? (a_i[d] & ~m_aprev[d]) : a_i[d];
        nxt  = m_pend[d];
        if (m_busy[d] && ack_i[d]) nxt[m_gidx[d]] = 1'b0;
        nxt = nxt | setv;
        if (m_busy[d]) begin
            if (ack_i[d]) begin
                m_last[d] = m_gidx[d];
                m_busy[d] = 1'b0;
            end
        end else begin
            w = pick(d);
            if (w >= 0) begin
                m_busy[d] = 1'b1;
                m_gidx[d] = w;
            end
        end
        m_pend[d]  = nxt;
        m_aprev[d] = a_i[d];
        m_z0[d]    = (nxt != 0);
    endtask

    function automatic logic [16:0] exp_word(int d);
        logic [10:0] g;
        g = '0;
        if (m_busy[d]) g[m_gidx[d]] = 1'b1;
        return {m_z0[d], m_busy[d], g, m_busy[d] ? 4'(m_gidx[d]) : 4'd0};
    endfunction

    function automatic logic [16:0] act_word(int d);
        return {z0_o[d], vld_o[d], gnt_o[d], idx_o[d]};
    endfunction

    // ---------------- stimulus plumbing ----------------
    task automatic tick();
        @(posedge ck);
        if (cdn) for (int d = 0; d < 3; d++) model_clock(d);
        @(negedge ck);
    endtask

    task automatic idle_inputs();
        for (int d = 0; d < 3; d++) begin a_i[d] = '0; ack_i[d] = 1'b0; end
    endtask

    task automatic apply_reset();
        idle_inputs();
        cdn = 1'b0;
        model_reset();
        @(posedge ck);
        @(negedge ck);
        cdn = 1'b1;
    endtask

    // The index may never leave 0..10 on any instance.
    always @(negedge ck) begin
        for (int d = 0; d < 3; d++) begin
            if (cdn && idx_o[d] > 4'd10) begin
                miscompares++;
                $display("FAIL idx_range d%0d: got %0d expected <=10", d, idx_o[d]);
            end
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin a_i[d] = 11'h7FF; ack_i[d] = 1'b0; end
        cdn = 1'b0;
        model_reset();
        @(posedge ck); @(posedge ck); @(negedge ck);
        for (int d = 0; d < 3; d++) begin
            vectors++;
            if (act_word(d) !== 17'h0) begin
                miscompares++;
                $display("FAIL reset_hold d%0d: got %h expected %h", d, act_word(d), 17'h0);
            end
        end
        cdn = 1'b1;
        tick();
        for (int d = 0; d < 3; d++) begin
            vectors++;
            if ({z0_o[d], vld_o[d]} !== 2'b10 || act_word(d) !== exp_word(d)) begin
                miscompares++;
                $display("FAIL reset_edge1 d%0d: got %h expected %h", d, act_word(d), exp_word(d));
            end
        end
        tick();
        for (int d = 0; d < 3; d++) begin
            vectors++;
            if ({vld_o[d], gnt_o[d], idx_o[d]} !== {1'b1, 11'h001, 4'd0}) begin
                miscompares++;
                $display("FAIL reset_edge2 d%0d: got vld=%b gnt=%h idx=%0d expected vld=1 gnt=001 idx=0",
                         d, vld_o[d], gnt_o[d], idx_o[d]);
            end
        end
    endtask

    task automatic test_rr_wrap();
        int seq[$];
        bit fin;
        apply_reset();
        for (int r = 0; r < 2; r++) begin
            seq.delete();
            a_i[0] = 11'h401;
            tick();
            a_i[0] = '0;
            for (int c = 0; c < 8; c++) begin
                ack_i[0] = vld_o[0];
                fin = vld_o[0] && (idx_o[0] == 4'd10);
                if (vld_o[0]) seq.push_back(int'(idx_o[0]));
                tick();
                vectors++;
                if (act_word(0) !== exp_word(0)) begin
                    miscompares++;
                    $display("FAIL rr_wrap_model r%0d c%0d: got %h expected %h", r, c, act_word(0), exp_word(0));
                end
                if (fin) begin
                    vectors++;
                    if (z0_o[0] !== 1'b0) begin
                        miscompares++;
                        $display("FAIL rr_wrap_z0_fall r%0d: got %b expected 0", r, z0_o[0]);
                    end
                end
            end
            ack_i[0] = 1'b0;
            vectors++;
            if (seq.size() != 2 || seq[0] != 0 || seq[1] != 10) begin
                miscompares++;
                $display("FAIL rr_wrap_seq r%0d: got %p expected '{0,10}", r, seq);
            end
        end
    endtask

    task automatic test_fixed_prio();
        int seq[$];
        apply_reset();
        a_i[1] = 11'h0A0;
        tick();
        a_i[1] = '0;
        for (int c = 0; c < 10; c++) begin
            ack_i[1] = vld_o[1];
            a_i[1]   = (vld_o[1] && idx_o[1] == 4'd5) ? 11'h002 : 11'h000;
            if (vld_o[1]) seq.push_back(int'(idx_o[1]));
            tick();
            vectors++;
            if (act_word(1) !== exp_word(1)) begin
                miscompares++;
                $display("FAIL fixed_model c%0d: got %h expected %h", c, act_word(1), exp_word(1));
            end
        end
        idle_inputs();
        vectors++;
        if (seq.size() != 3 || seq[0] != 5 || seq[1] != 1 || seq[2] != 7) begin
            miscompares++;
            $display("FAIL fixed_seq: got %p expected '{5,1,7}", seq);
        end
    endtask

    task automatic test_edge();
        int ngr;
        int gi;
        apply_reset();
        for (int pass = 0; pass < 2; pass++) begin
            ngr = 0;
            gi  = -1;
            a_i[2] = 11'h008;
            for (int c = 0; c < 10; c++) begin
                ack_i[2] = vld_o[2];
                if (vld_o[2]) begin ngr++; gi = int'(idx_o[2]); end
                tick();
                vectors++;
                if (act_word(2) !== exp_word(2)) begin
                    miscompares++;
                    $display("FAIL edge_model p%0d c%0d: got %h expected %h", pass, c, act_word(2), exp_word(2));
                end
            end
            vectors++;
            if (ngr != 1 || gi != 3 || z0_o[2] !== 1'b0) begin
                miscompares++;
                $display("FAIL edge_once p%0d: got grants=%0d idx=%0d z0=%b expected grants=1 idx=3 z0=0",
                         pass, ngr, gi, z0_o[2]);
            end
            a_i[2]   = '0;
            ack_i[2] = 1'b0;
            tick();
        end
    endtask

    task automatic test_set_clear();
        apply_reset();
        a_i[0] = 11'h010;
        tick();
        tick();
        vectors++;
        if ({vld_o[0], idx_o[0]} !== {1'b1, 4'd4}) begin
            miscompares++;
            $display("FAIL setclr_grant1: got vld=%b idx=%0d expected vld=1 idx=4", vld_o[0], idx_o[0]);
        end
        ack_i[0] = 1'b1;
        tick();
        vectors++;
        if ({z0_o[0], vld_o[0]} !== 2'b10) begin
            miscompares++;
            $display("FAIL setclr_bubble: got z0=%b vld=%b expected z0=1 vld=0", z0_o[0], vld_o[0]);
        end
        ack_i[0] = 1'b0;
        tick();
        vectors++;
        if ({vld_o[0], gnt_o[0], idx_o[0]} !== {1'b1, 11'h010, 4'd4}) begin
            miscompares++;
            $display("FAIL setclr_regrant: got vld=%b gnt=%h idx=%0d expected vld=1 gnt=010 idx=4",
                     vld_o[0], gnt_o[0], idx_o[0]);
        end
        a_i[0]   = '0;
        ack_i[0] = 1'b1;
        tick();
        ack_i[0] = 1'b0;
        tick();
        vectors++;
        if ({z0_o[0], vld_o[0]} !== 2'b00 || act_word(0) !== exp_word(0)) begin
            miscompares++;
            $display("FAIL setclr_drain: got %h expected %h", act_word(0), exp_word(0));
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        a_i[0] = 11'h040;
        tick();
        a_i[0] = '0;
        tick();
        vectors++;
        if ({vld_o[0], idx_o[0]} !== {1'b1, 4'd6}) begin
            miscompares++;
            $display("FAIL midrst_grant: got vld=%b idx=%0d expected vld=1 idx=6", vld_o[0], idx_o[0]);
        end
        #2 cdn = 1'b0;
        model_reset();
        #1;
        vectors++;
        if ({z0_o[0], vld_o[0], gnt_o[0]} !== 13'h0) begin
            miscompares++;
            $display("FAIL midrst_async: got z0=%b vld=%b gnt=%h expected all 0", z0_o[0], vld_o[0], gnt_o[0]);
        end
        @(negedge ck);
        cdn = 1'b1;
        repeat (4) tick();
        vectors++;
        if (vld_o[0] !== 1'b0 || z0_o[0] !== 1'b0 || act_word(0) !== exp_word(0)) begin
            miscompares++;
            $display("FAIL midrst_idle: got %h expected %h", act_word(0), exp_word(0));
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            for (int d = 0; d < 3; d++) begin
                a_i[d]   = 11'($urandom & $urandom & $urandom);
                ack_i[d] = 1'($urandom_range(0, 1));
            end
            tick();
            for (int d = 0; d < 3; d++) begin
                vectors++;
                if (act_word(d) !== exp_word(d)) begin
                    miscompares++;
                    $display("FAIL random d%0d c%0d: got %h expected %h", d, c, act_word(d), exp_word(d));
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_rr_wrap();
        test_fixed_prio();
        test_edge();
        test_set_clear();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_req11_resolver
`default_nettype wire
